// File: rtl/wb_queue_stage.sv
// ---------------------------------------------------------------------------
// wb_queue_stage
//
// Write-back stage with a pending-write queue. Each accepted instruction
// selects its ALU or memory result; register writes are buffered in a
// DEPTH-entry FIFO so the register-file write port can stall without
// back-pressuring the pipeline until the queue fills. Decode can look up
// the youngest queued value for a source register.
//
// Optional build macro: WB_QUEUE_STATS_EN adds the stat_writes/stat_stalls
// counters and their output ports.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-low reset
//   flush             discard every queued entry (and any same-cycle push)
//   in_valid/in_ready upstream handshake; in_ready = queue not full
//   in_wb_en, in_sel  write enable, result select (0 ALU, 1 memory)
//   in_alu, in_mem    candidate results
//   in_rd             destination register
//   wr_en/addr/data   head of queue toward the register file
//   rf_ready          register file takes the head this cycle
//   fwd_addr          decode lookup address
//   fwd_hit/fwd_data  youngest pending value for fwd_addr
//   count             occupied entries
//   stat_writes       (stats build) number of pops, saturating
//   stat_stalls       (stats build) cycles with wr_en & ~rf_ready, saturating
// ---------------------------------------------------------------------------
module wb_queue_stage #(
    parameter int ARQ      = 16,
    parameter int REG_ADDR = 4,
    parameter int DEPTH    = 4,
    parameter int ZERO_REG = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_wb_en,
    input  logic                         in_sel,
    input  logic [ARQ-1:0]               in_alu,
    input  logic [ARQ-1:0]               in_mem,
    input  logic [REG_ADDR-1:0]          in_rd,
    output logic                         wr_en,
    output logic [REG_ADDR-1:0]          wr_addr,
    output logic [ARQ-1:0]               wr_data,
    input  logic                         rf_ready,
    input  logic [REG_ADDR-1:0]          fwd_addr,
    output logic                         fwd_hit,
    output logic [ARQ-1:0]               fwd_data,
`ifdef WB_QUEUE_STATS_EN
    output logic [31:0]                  stat_writes,
    output logic [31:0]                  stat_stalls,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [REG_ADDR-1:0] rd_mem_q   [DEPTH];
    logic [ARQ-1:0]      data_mem_q [DEPTH];

    logic [PTR_W-1:0]    occ;
    logic [IDX_W-1:0]    head_idx;
    logic [IDX_W-1:0]    tail_idx;
    logic [IDX_W-1:0]    slot;
    logic                accept;
    logic                push;
    logic                pop;
    logic                rd_is_zero;

    // The extra pointer MSB makes the difference equal DEPTH when full.
    assign occ      = wr_ptr_q - rd_ptr_q;
    assign count    = CNT_W'(occ);
    assign head_idx = rd_ptr_q[IDX_W-1:0];
    assign tail_idx = wr_ptr_q[IDX_W-1:0];

    assign in_ready   = (occ != PTR_W'(DEPTH));
    assign accept     = in_valid & in_ready;
    assign rd_is_zero = (ZERO_REG != 0) && (in_rd == '0);
    assign push       = accept & in_wb_en & ~rd_is_zero;

    assign wr_en   = (occ != '0);
    assign wr_addr = wr_en ? rd_mem_q[head_idx]   : '0;
    assign wr_data = wr_en ? data_mem_q[head_idx] : '0;
    assign pop     = wr_en & rf_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage needs no reset: it is only observed while counted valid.
    always_ff @(posedge clk) begin
        if (rst && push && !flush) begin
            rd_mem_q[tail_idx]   <= in_rd;
            data_mem_q[tail_idx] <= in_sel ? in_mem : in_alu;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_idx + IDX_W'(i);
            if ((PTR_W'(i) < occ) && (rd_mem_q[slot] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem_q[slot];
            end
        end
        if ((ZERO_REG != 0) && (fwd_addr == '0)) begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end

`ifdef WB_QUEUE_STATS_EN
    logic [31:0] stat_writes_q;
    logic [31:0] stat_stalls_q;

    // Counters ignore flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_writes_q <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (pop && (stat_writes_q != 32'hFFFF_FFFF))
                stat_writes_q <= stat_writes_q + 32'd1;
            if (wr_en && !rf_ready && (stat_stalls_q != 32'hFFFF_FFFF))
                stat_stalls_q <= stat_stalls_q + 32'd1;
        end
    end

    assign stat_writes = stat_writes_q;
    assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_wb_queue_stage.sv
module tb_wb_queue_stage;

    localparam int DEPTH = 4;
    localparam int NV    = 25;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_wb_en;
    logic        in_sel;
    logic [15:0] in_alu;
    logic [15:0] in_mem;
    logic [3:0]  in_rd;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rf_ready;
    logic [3:0]  fwd_addr;
    logic        fwd_hit;
    logic [15:0] fwd_data;
    logic [2:0]  count;
`ifdef WB_QUEUE_STATS_EN
    logic [31:0] stat_writes;
    logic [31:0] stat_stalls;
`endif

    wb_queue_stage #(.ARQ(16), .REG_ADDR(4), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_wb_en (in_wb_en),
        .in_sel   (in_sel),
        .in_alu   (in_alu),
        .in_mem   (in_mem),
        .in_rd    (in_rd),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rf_ready (rf_ready),
        .fwd_addr (fwd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data),
`ifdef WB_QUEUE_STATS_EN
        .stat_writes (stat_writes),
        .stat_stalls (stat_stalls),
`endif
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        v;
        logic        wb;
        logic        sel;
        logic [15:0] alu;
        logic [15:0] mem;
        logic [3:0]  rd;
        logic        rf;
        logic [3:0]  fa;
        logic        chk;
        logic        e_rdy;
        logic        e_wen;
        logic [3:0]  e_addr;
        logic [15:0] e_data;
        logic        e_hit;
        logic [15:0] e_fdata;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs [NV];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_pops   = 0;
    int exp_stalls = 0;
    logic [19:0] mq [$];

    function automatic vec_t mk(input logic r, input logic v, input logic wb, input logic sel,
                                input logic [15:0] alu, input logic [15:0] mem, input logic [3:0] rd,
                                input logic rf, input logic [3:0] fa, input logic chk,
                                input logic e_rdy, input logic e_wen, input logic [3:0] e_addr,
                                input logic [15:0] e_data, input logic e_hit,
                                input logic [15:0] e_fdata, input logic [2:0] e_cnt);
        vec_t t;
        t.r = r; t.v = v; t.wb = wb; t.sel = sel; t.alu = alu; t.mem = mem; t.rd = rd;
        t.rf = rf; t.fa = fa; t.chk = chk; t.e_rdy = e_rdy; t.e_wen = e_wen;
        t.e_addr = e_addr; t.e_data = e_data; t.e_hit = e_hit; t.e_fdata = e_fdata;
        t.e_cnt = e_cnt;
        return t;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // One cycle of sequence stimulus checked against a queue model.
    task automatic step(input logic v, input logic [3:0] rd, input logic [15:0] d,
                        input logic rf, input logic fl, input string tag);
        int  sz;
        logic do_push;
        @(negedge clk);
        rst = 1'b1; flush = fl; in_valid = v; in_wb_en = 1'b1; in_sel = 1'b0;
        in_alu = d; in_mem = ~d; in_rd = rd; rf_ready = rf; fwd_addr = 4'd0;
        #1;
        sz = mq.size();
        check({tag, "_cnt"}, 32'(count), 32'(sz));
        check({tag, "_cnt_le"}, 32'(count <= 3'(DEPTH)), 32'd1);
        check({tag, "_rdy"}, 32'(in_ready), 32'(sz < DEPTH));
        check({tag, "_wen"}, 32'(wr_en), 32'(sz != 0));
        if (sz != 0) begin
            check({tag, "_addr"}, 32'(wr_addr), 32'(mq[0][19:16]));
            check({tag, "_data"}, 32'(wr_data), 32'(mq[0][15:0]));
            if (rf) exp_pops++;
            else    exp_stalls++;
        end
        do_push = v && (sz < DEPTH);
        @(posedge clk);
        if (fl) mq.delete();
        else begin
            if (sz != 0 && rf) void'(mq.pop_front());
            if (do_push) mq.push_back({rd, d});
        end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_wb_en = 1'b0; in_sel = 1'b0;
        in_alu = '0; in_mem = '0; in_rd = '0; rf_ready = 1'b0; fwd_addr = '0;

        //              r  v  wb sel alu       mem       rd  rf fa chk rdy wen addr data      hit fdata     cnt
        vecs[0]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0);
        vecs[1]  = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0);
        vecs[2]  = mk(1, 1, 1, 0, 16'h00A5, 16'hFFFF, 3, 1, 3, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0);
        vecs[3]  = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 3, 1, 1, 1, 3, 16'h00A5, 1, 16'h00A5, 1);
        vecs[4]  = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 3, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0);
        vecs[5]  = mk(1, 1, 1, 1, 16'hDEAD, 16'h1111, 1, 0, 0, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0);
        vecs[6]  = mk(1, 1, 1, 1, 16'hDEAD, 16'h2222, 2, 0, 0, 1, 1, 1, 1, 16'h1111, 0, 16'h0000, 1);
        vecs[7]  = mk(1, 1, 1, 1, 16'hDEAD, 16'h3333, 3, 0, 0, 1, 1, 1, 1, 16'h1111, 0, 16'h0000, 2);
        vecs[8]  = mk(1, 1, 1, 1, 16'hDEAD, 16'h4444, 4, 0, 0, 1, 1, 1, 1, 16'h1111, 0, 16'h0000, 3);
        vecs[9]  = mk(1, 1, 1, 1, 16'hDEAD, 16'h5555, 5, 0, 4, 1, 0, 1, 1, 16'h1111, 1, 16'h4444, 4);
        vecs[10] = mk(1, 1, 1, 1, 16'hDEAD, 16'h5555, 5, 1, 1, 1, 0, 1, 1, 16'h1111, 1, 16'h1111, 4);
        vecs[11] = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 5, 1, 1, 1, 2, 16'h2222, 0, 16'h0000, 3);
        vecs[12] = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 2, 1, 1, 1, 3, 16'h3333, 0, 16'h0000, 2);
        vecs[13] = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 4, 1, 1, 1, 4, 16'h4444, 1, 16'h4444, 1);
        vecs[14] = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0);
        vecs[15] = mk(1, 1, 1, 0, 16'h0001, 16'hFFFF, 5, 0, 5, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0);
        vecs[16] = mk(1, 1, 1, 0, 16'h0002, 16'hFFFF, 5, 0, 5, 1, 1, 1, 5, 16'h0001, 1, 16'h0001, 1);
        vecs[17] = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 5, 1, 1, 1, 5, 16'h0001, 1, 16'h0002, 2);
        vecs[18] = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 6, 1, 1, 1, 5, 16'h0001, 0, 16'h0000, 2);
        vecs[19] = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 5, 1, 1, 1, 5, 16'h0001, 1, 16'h0002, 2);
        vecs[20] = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 5, 1, 1, 1, 5, 16'h0002, 1, 16'h0002, 1);
        vecs[21] = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 5, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0);
        vecs[22] = mk(1, 1, 1, 0, 16'h1234, 16'h0000, 0, 1, 0, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0);
        vecs[23] = mk(1, 1, 0, 0, 16'h5678, 16'h0000, 7, 1, 0, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0);
        vecs[24] = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 7, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0);

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            rst = vecs[k].r; flush = 1'b0; in_valid = vecs[k].v; in_wb_en = vecs[k].wb;
            in_sel = vecs[k].sel; in_alu = vecs[k].alu; in_mem = vecs[k].mem;
            in_rd = vecs[k].rd; rf_ready = vecs[k].rf; fwd_addr = vecs[k].fa;
            #1;
            if (vecs[k].chk) begin
                check($sformatf("v%0d_rdy", k),   32'(in_ready), 32'(vecs[k].e_rdy));
                check($sformatf("v%0d_wen", k),   32'(wr_en),    32'(vecs[k].e_wen));
                check($sformatf("v%0d_addr", k),  32'(wr_addr),  32'(vecs[k].e_addr));
                check($sformatf("v%0d_data", k),  32'(wr_data),  32'(vecs[k].e_data));
                check($sformatf("v%0d_hit", k),   32'(fwd_hit),  32'(vecs[k].e_hit));
                check($sformatf("v%0d_fdata", k), 32'(fwd_data), 32'(vecs[k].e_fdata));
                check($sformatf("v%0d_cnt", k),   32'(count),    32'(vecs[k].e_cnt));
                if (vecs[k].r && vecs[k].e_wen && vecs[k].rf)  exp_pops++;
                if (vecs[k].r && vecs[k].e_wen && !vecs[k].rf) exp_stalls++;
            end
        end

        // Fill with the register file stalled, then stream 2*DEPTH cycles.
        for (int k = 0; k < DEPTH; k++)
            step(1'b1, 4'(k + 1), 16'hA000 + 16'(k), 1'b0, 1'b0, "fill");
        for (int k = 0; k < 2 * DEPTH; k++)
            step(1'b1, 4'(8 + k), 16'hB000 + 16'(k * 7), 1'b1, 1'b0, "wrap");
        for (int k = 0; k < 2 * DEPTH; k++) begin
            if (mq.size() == 0) break;
            step(1'b0, 4'd1, 16'h0000, 1'b1, 1'b0, "drain");
        end
        step(1'b0, 4'd1, 16'h0000, 1'b0, 1'b0, "idle");

`ifdef WB_QUEUE_STATS_EN
        @(negedge clk); #1;
        check("stat_writes", stat_writes, 32'(exp_pops));
        check("stat_stalls", stat_stalls, 32'(exp_stalls));
`endif

        // Flush with a simultaneous accepted push.
        step(1'b1, 4'd9,  16'hC001, 1'b0, 1'b0, "pre");
        step(1'b1, 4'd10, 16'hC002, 1'b0, 1'b0, "pre");
        step(1'b1, 4'd11, 16'hC003, 1'b0, 1'b0, "pre");
        step(1'b1, 4'd12, 16'hC004, 1'b0, 1'b1, "flush");
        step(1'b0, 4'd1,  16'h0000, 1'b1, 1'b0, "postfl");
        @(negedge clk); #1;
        check("postfl_fwd_hit", 32'(fwd_hit), 32'd0);

        // Reset in the middle of a drain.
        step(1'b1, 4'd13, 16'hD001, 1'b0, 1'b0, "pre2");
        step(1'b1, 4'd14, 16'hD002, 1'b0, 1'b0, "pre2");
        step(1'b1, 4'd15, 16'hD003, 1'b0, 1'b0, "pre2");
        step(1'b0, 4'd1,  16'h0000, 1'b1, 1'b0, "drain2");
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; in_rd = 4'd6; in_alu = 16'hEEEE; rf_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; rf_ready = 1'b0; fwd_addr = 4'd14;
        #1;
        mq.delete();
        check("rst_wen",   32'(wr_en),    32'd0);
        check("rst_addr",  32'(wr_addr),  32'd0);
        check("rst_data",  32'(wr_data),  32'd0);
        check("rst_hit",   32'(fwd_hit),  32'd0);
        check("rst_fdata", 32'(fwd_data), 32'd0);
        check("rst_cnt",   32'(count),    32'd0);
        check("rst_rdy",   32'(in_ready), 32'd1);
`ifdef WB_QUEUE_STATS_EN
        check("rst_stat_writes", stat_writes, 32'd0);
        check("rst_stat_stalls", stat_stalls, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
